// File: rtl/seq_stream_checker_if.sv
// Beat bus for seq_stream_checker: valid/ready handshake carrying one addr/data pair.
// The producer uses the master modport and the checker uses the slave modport.
interface seq_stream_checker_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/seq_stream_checker.sv
// seq_stream_checker: sink-side monitor for an incrementing addr/data stream.
// The first accepted beat seeds the expectation, and every later beat must follow
// the +1 sequence. The checker reports lock, error counts and a first-error snapshot.
// Optional feature macro: SEQ_CHK_RESYNC_EN. When it is defined, a mismatch reloads
// the expectation from the received beat. When it is undefined, the expectation keeps
// advancing from the old value.
module seq_stream_checker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  enable,
    input  logic                  clr,
    seq_stream_checker_if.slave   in_bus,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic                  first_err_valid,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic [DATA_WIDTH-1:0] first_err_exp
);
    localparam int unsigned RunW = $clog2(LOCK_COUNT + 1);
    localparam logic [RunW-1:0] LockMax = RunW'(LOCK_COUNT);

    typedef enum logic [1:0] {StIdle, StSeed, StCheck} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [DATA_WIDTH-1:0] exp_data;
    logic [RunW-1:0]       run_cnt;
    logic                  accept;
    logic                  match;
    logic [RunW-1:0]       run_inc;

    assign in_bus.in_ready = enable & ~clr;
    assign accept          = in_bus.in_valid & in_bus.in_ready;
    assign match           = (in_bus.in_addr == exp_addr) && (in_bus.in_data == exp_data);
    assign run_inc         = (run_cnt == LockMax) ? run_cnt : run_cnt + RunW'(1);

    // FSM, expectations, counters and the snapshot, all updated on one edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state           <= StIdle;
            exp_addr        <= '0;
            exp_data        <= '0;
            run_cnt         <= '0;
            locked          <= 1'b0;
            err_pulse       <= 1'b0;
            err_cnt         <= '0;
            beat_cnt        <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_data  <= '0;
            first_err_exp   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clr) begin
                state           <= StIdle;
                run_cnt         <= '0;
                locked          <= 1'b0;
                err_cnt         <= '0;
                beat_cnt        <= '0;
                first_err_valid <= 1'b0;
                first_err_addr  <= '0;
                first_err_data  <= '0;
                first_err_exp   <= '0;
            end else if (!enable) begin
                state <= StIdle;
            end else begin
                if (accept && beat_cnt != '1) begin
                    beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                end
                unique case (state)
                    // in_ready is already high in IDLE once enable rises. A beat
                    // taken in that cycle seeds, so it is never silently lost.
                    StIdle, StSeed: begin
                        if (accept) begin
                            exp_addr <= in_bus.in_addr + ADDR_WIDTH'(1);
                            exp_data <= in_bus.in_data + DATA_WIDTH'(1);
                            run_cnt  <= '0;
                            locked   <= 1'b0;
                            state    <= StCheck;
                        end else begin
                            state <= StSeed;
                        end
                    end
                    StCheck: begin
                        if (accept && match) begin
                            run_cnt  <= run_inc;
                            locked   <= (run_inc == LockMax);
                            exp_addr <= exp_addr + ADDR_WIDTH'(1);
                            exp_data <= exp_data + DATA_WIDTH'(1);
                        end else if (accept) begin
                            err_pulse <= 1'b1;
                            run_cnt   <= '0;
                            locked    <= 1'b0;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + CNT_WIDTH'(1);
                            end
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_addr  <= in_bus.in_addr;
                                first_err_data  <= in_bus.in_data;
                                first_err_exp   <= exp_data;
                            end
`ifdef SEQ_CHK_RESYNC_EN
                            exp_addr <= in_bus.in_addr + ADDR_WIDTH'(1);
                            exp_data <= in_bus.in_data + DATA_WIDTH'(1);
`else
                            exp_addr <= exp_addr + ADDR_WIDTH'(1);
                            exp_data <= exp_data + DATA_WIDTH'(1);
`endif
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq_stream_checker.sv
// Self-checking bench for seq_stream_checker. It runs directed test-plan steps and
// then randomized streams. Every cycle is compared against a behavioural model of the
// checking rules.
module tb_seq_stream_checker;
    localparam int LOCK = 4;
    localparam int CMAX = 65535;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        enable  = 1'b0;
    logic        clr     = 1'b0;
    logic        locked, err_pulse, first_err_valid;
    logic [15:0] err_cnt, beat_cnt;
    logic [31:0] first_err_addr, first_err_data, first_err_exp;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit          m_seeded, m_locked, m_pulse, m_fev;
    logic [31:0] m_exp_a, m_exp_d, m_fa, m_fd, m_fe;
    int          m_run, m_errs, m_beats;

    seq_stream_checker_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    seq_stream_checker #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16), .LOCK_COUNT(LOCK)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .enable         (enable),
        .clr            (clr),
        .in_bus         (bus),
        .locked         (locked),
        .err_pulse      (err_pulse),
        .err_cnt        (err_cnt),
        .beat_cnt       (beat_cnt),
        .first_err_valid(first_err_valid),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data),
        .first_err_exp  (first_err_exp)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_seeded = 0; m_locked = 0; m_pulse = 0; m_fev = 0;
        m_exp_a = 0; m_exp_d = 0; m_fa = 0; m_fd = 0; m_fe = 0;
        m_run = 0; m_errs = 0; m_beats = 0;
    endtask

    // One clock edge of the checking rules.
    task automatic model(input bit en, input bit c, input bit v,
                         input logic [31:0] a, input logic [31:0] d);
        m_pulse = 0;
        if (c) begin
            m_seeded = 0; m_run = 0; m_locked = 0; m_errs = 0; m_beats = 0;
            m_fev = 0; m_fa = 0; m_fd = 0; m_fe = 0;
        end else if (!en) begin
            m_seeded = 0;
        end else if (v) begin
            if (m_beats < CMAX) m_beats++;
            if (!m_seeded) begin
                m_seeded = 1; m_exp_a = a + 1; m_exp_d = d + 1; m_run = 0; m_locked = 0;
            end else if (a == m_exp_a && d == m_exp_d) begin
                if (m_run < LOCK) m_run++;
                m_locked = (m_run == LOCK);
                m_exp_a++; m_exp_d++;
            end else begin
                m_pulse = 1; m_run = 0; m_locked = 0;
                if (m_errs < CMAX) m_errs++;
                if (!m_fev) begin
                    m_fev = 1; m_fa = a; m_fd = d; m_fe = m_exp_d;
                end
`ifdef SEQ_CHK_RESYNC_EN
                m_exp_a = a + 1; m_exp_d = d + 1;
`else
                m_exp_a++; m_exp_d++;
`endif
            end
        end
    endtask

    task automatic check_all();
        check("locked", locked, m_locked);
        check("err_pulse", err_pulse, m_pulse);
        check("err_cnt", err_cnt, m_errs);
        check("beat_cnt", beat_cnt, m_beats);
        check("first_err_valid", first_err_valid, m_fev);
        check("first_err_addr", first_err_addr, m_fa);
        check("first_err_data", first_err_data, m_fd);
        check("first_err_exp", first_err_exp, m_fe);
    endtask

    // Called just after an edge: drive, check in_ready, clock, update model, compare.
    task automatic step(input bit en, input bit c, input bit v,
                        input logic [31:0] a, input logic [31:0] d);
        enable = en; clr = c; bus.in_valid = v; bus.in_addr = a; bus.in_data = d;
        #1;
        check("in_ready", bus.in_ready, en & ~c);
        @(posedge sys_clk);
        model(en, c, v, a, d);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] v, a, d;
        bit          vld;

        bus.in_valid = 0; bus.in_addr = 0; bus.in_data = 0;
        model_reset();
        #2;
        check_all();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 0;

        // Continuous stream 0..99
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(1, 0, 1, i, i);
        check("tp_stream_beats", beat_cnt, 100);
        check("tp_stream_errs", err_cnt, 0);
        check("tp_stream_locked", locked, 1);
        check("tp_stream_fev", first_err_valid, 0);

        // Wrap through 2^32
        step(1, 1, 0, 0, 0);
        v = 32'hFFFF_FFFD;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, v, v);
            v++;
        end
        check("tp_wrap_errs", err_cnt, 0);
        check("tp_wrap_locked", locked, 1);

        // Jump 0..9 then 20..29
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, i, i);
        for (int i = 20; i < 30; i++) step(1, 0, 1, i, i);
`ifdef SEQ_CHK_RESYNC_EN
        check("tp_jump_errs", err_cnt, 1);
        check("tp_jump_locked", locked, 1);
`else
        check("tp_jump_errs", err_cnt, 10);
        check("tp_jump_locked", locked, 0);
`endif
        check("tp_jump_fdata", first_err_data, 20);
        check("tp_jump_fexp", first_err_exp, 10);

        // Gapped valid, every third cycle
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 90; i++) step(1, 0, (i % 3) == 0, i / 3, i / 3);
        check("tp_gap_beats", beat_cnt, 30);
        check("tp_gap_errs", err_cnt, 0);

        // clr with valid high is not accepted, and the next beat re-seeds
        for (int i = 0; i < 5; i++) step(1, 0, 1, 100 + i, 100 + i);
        step(1, 1, 1, 105, 105);
        check("tp_clr_beats", beat_cnt, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, 300 + i, 300 + i);
        check("tp_clr_errs", err_cnt, 0);
        check("tp_clr_beats2", beat_cnt, 6);

        // Drop enable after 5 beats, re-enable at 50
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, i, i);
        step(0, 0, 1, 5, 5);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 50; i < 56; i++) step(1, 0, 1, i, i);
        check("tp_reen_errs", err_cnt, 0);
        check("tp_reen_beats", beat_cnt, 11);

        // Randomized streams with gaps, corruption and enable drops
        for (int r = 0; r < 8; r++) begin
            v = $urandom;
            step(1, ($urandom_range(0, 2) == 0), 0, 0, 0);
            for (int i = 0; i < 50; i++) begin
                vld = ($urandom_range(0, 3) != 0);
                a = v;
                d = v;
                if ($urandom_range(0, 9) == 0) d = $urandom;
                if ($urandom_range(0, 19) == 0) a = a + 7;
                step(1, 0, vld, a, d);
                if (vld) v++;
            end
            step(0, 0, $urandom_range(0, 1), v, v);
        end

        // Asynchronous reset between edges
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 1, i, (i == 3) ? 32'h55 : i);
        #3 sys_rst = 1;
        #1;
        model_reset();
        check("arst_locked", locked, 0);
        check("arst_pulse", err_pulse, 0);
        check("arst_errs", err_cnt, 0);
        check("arst_beats", beat_cnt, 0);
        check("arst_fev", first_err_valid, 0);
        check("arst_fdata", first_err_data, 0);
        check("arst_fexp", first_err_exp, 0);
        enable = 0;
        @(posedge sys_clk);
        #1 sys_rst = 0;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 70 + i, 70 + i);
        check("arst_resume_errs", err_cnt, 0);
        check("arst_resume_locked", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
